// File: rtl/spi_mem_readback.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_mem_readback
//
// SPI-slave memory dumper. While the host holds device_mem_read_en high, the
// core is held in reset and memory is read one byte at a time from address 0
// upward. Each byte is shifted out on device_MISO, SPI mode 0, MSB first.
// One byte is prefetched into a buffer so that the next byte is ready by the
// time the shifter needs it.
//
// Optional feature (macro SPI_READBACK_LIMIT_EN): reads stop after address
// MEM_BYTES-1. Later bytes are sent as 0x00 and next_addr stays at MEM_BYTES.
// Without the macro, reads continue and the address wraps at 2^ADDR_W.
//
// Ports:
//   clk, rstn           system clock, synchronous active-low reset
//   device_mem_read_en  host dump request (level)
//   core_dump_resetn    core reset, active-low, = ~device_mem_read_en
//   mem_read_addr       byte address to memory
//   mem_read_en         one-cycle read strobe
//   mem_read_data       read data, valid one clk after mem_read_en
//   device_SCK/CSn      SPI clock / chip select from host (asynchronous)
//   device_MOSI         unused
//   device_MISO         serial data to host
// -----------------------------------------------------------------------------
module spi_mem_readback #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              device_mem_read_en,
   output logic              core_dump_resetn,
   output logic [ADDR_W-1:0] mem_read_addr,
   output logic              mem_read_en,
   input  logic [7:0]        mem_read_data,
   input  logic              device_SCK,
   input  logic              device_CSn,
   input  logic              device_MOSI,
   output logic              device_MISO
);

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      FETCH    = 2'd1,
      WAIT     = 2'd2,
      HOLD     = 2'd3
   } state_t;

   state_t            state, state_nxt;

   logic [1:0]        sck_sync, csn_sync;
   logic              sck_d, csn_d;
   logic              sck_s, csn_s;
   logic              sck_fall, csn_fall;

   logic [ADDR_W-1:0] next_addr;
   logic [7:0]        buffer, shifter, load_val;
   logic              buf_valid;
   logic              sh_full;     // shifter holds a whole byte with no bit sent yet
   logic [2:0]        bit_cnt;
   logic              frame_start, sck_shift, fetch_ok;
   logic              unused_inputs;

   // MOSI is never loaded; MEM_BYTES only matters with the limit enabled.
   assign unused_inputs = ^{device_MOSI, MEM_BYTES};

   // Two-flop synchronizers plus one delayed copy for edge detection.
   // NOTE: reset is synchronous here, so rstn is tested inside the clocked
   // branch and never appears in the sensitivity list; state updates use <=
   // so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sck_sync <= 2'b00;
         sck_d    <= 1'b0;
         csn_sync <= 2'b11;
         csn_d    <= 1'b1;
      end else begin
         sck_sync <= {sck_sync[0], device_SCK};
         sck_d    <= sck_sync[1];
         csn_sync <= {csn_sync[0], device_CSn};
         csn_d    <= csn_sync[1];
      end
   end

   assign sck_s    = sck_sync[1];
   assign csn_s    = csn_sync[1];
   assign sck_fall = sck_d & ~sck_s;
   assign csn_fall = csn_d & ~csn_s;

`ifdef SPI_READBACK_LIMIT_EN
   assign fetch_ok = (next_addr != ADDR_W'(MEM_BYTES));
`else
   assign fetch_ok = 1'b1;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) state <= DISABLED;
      else       state <= state_nxt;
   end

   // FSM next state and read strobe.
   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      mem_read_en = 1'b0;
      case (state)
         DISABLED: if (device_mem_read_en) state_nxt = FETCH;
         FETCH: begin
            mem_read_en = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT:     state_nxt = HOLD;
         HOLD:     if (!buf_valid && fetch_ok) state_nxt = FETCH;
         default:  state_nxt = DISABLED;
      endcase
      if (!device_mem_read_en) state_nxt = DISABLED;
   end

   assign mem_read_addr    = next_addr;
   assign core_dump_resetn = ~device_mem_read_en;

   // A byte is sent as 0x00 whenever the prefetch buffer is empty.
   assign load_val    = buf_valid ? buffer : 8'h00;
   assign frame_start = csn_fall && (state != DISABLED);
   assign sck_shift   = sck_fall && !csn_s && !frame_start;

   // NOTE: the prefetch buffer has no reset; its content is ignored while
   // buf_valid is low, so a reset would only cost routing.
   always_ff @(posedge clk) begin
      if (state == WAIT) buffer <= mem_read_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn || state == DISABLED) begin
         next_addr <= '0;
         buf_valid <= 1'b0;
         shifter   <= 8'h00;
         bit_cnt   <= 3'd0;
         sh_full   <= 1'b0;
      end else begin
         if (state == WAIT) next_addr <= next_addr + ADDR_W'(1);

         // A fresh capture wins over a consume in the same cycle: the
         // consume then took 0x00 from the still-empty buffer.
         if (state == WAIT)
            buf_valid <= 1'b1;
         else if ((frame_start && !sh_full) || (sck_shift && bit_cnt == 3'd7))
            buf_valid <= 1'b0;

         if (frame_start) begin
            bit_cnt <= 3'd0;
            // A byte loaded at the end of the previous frame with none of its
            // bits sent is kept; a partially sent byte is dropped.
            if (!sh_full) begin
               shifter <= load_val;
               sh_full <= buf_valid;
            end
         end else if (sck_shift) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               shifter <= load_val;
               sh_full <= buf_valid;
            end else begin
               shifter <= {shifter[6:0], 1'b0};
               sh_full <= 1'b0;
            end
         end
      end
   end

   assign device_MISO = (csn_s || state == DISABLED) ? 1'b0 : shifter[7];

endmodule

// File: tb/tb_spi_mem_readback.sv
`timescale 1ns/1ps
// Self-checking bench for spi_mem_readback. The host side is modelled as a
// byte stream: a frame of n SCK pulses delivers the first n bits of the stream
// starting at the next undelivered byte and uses up ceil(n/8) bytes.
module tb_spi_mem_readback;

   localparam int ADDR_W    = 32;
   localparam int MEM_BYTES = 4;
`ifdef SPI_READBACK_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic              clk  = 1'b0;
   logic              rstn = 1'b0;
   logic              en   = 1'b0;
   logic              sck  = 1'b0;
   logic              csn  = 1'b1;
   logic              mosi = 1'b0;
   logic              core_dump_resetn;
   logic              mem_read_en;
   logic [ADDR_W-1:0] mem_read_addr;
   logic [7:0]        mem_read_data = 8'h00;
   logic              miso;

   always #5 clk = ~clk;

   spi_mem_readback #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .device_mem_read_en(en),
      .core_dump_resetn  (core_dump_resetn),
      .mem_read_addr     (mem_read_addr),
      .mem_read_en       (mem_read_en),
      .mem_read_data     (mem_read_data),
      .device_SCK        (sck),
      .device_CSn        (csn),
      .device_MOSI       (mosi),
      .device_MISO       (miso)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]        mem [256];
   int                ptr = 0;           // next stream byte the host will receive
   int                exp_addr = 0;      // next address the DUT must strobe
   int                strobes = 0;
   logic [ADDR_W-1:0] addr_log [$];

   function automatic logic [7:0] byte_at(input int idx);
      if (LIMIT && idx >= MEM_BYTES) return 8'h00;
      return mem[idx % 256];
   endfunction

   // Memory: data valid during the cycle after the strobe, garbage otherwise.
   logic       pend = 1'b0;
   logic [7:0] pend_idx = 8'h00;
   always @(negedge clk) begin
      mem_read_data = (pend === 1'b1) ? mem[pend_idx] : 8'($urandom);
      pend          = mem_read_en;
      pend_idx      = mem_read_addr[7:0];
   end

   // Per-cycle compare process.
   int rst_cnt = 0, en_low_cnt = 0, csn_high_cnt = 0;
   always @(posedge clk) begin
      #1;
      rst_cnt      = rstn ? 0 : rst_cnt + 1;
      en_low_cnt   = en ? 0 : en_low_cnt + 1;
      csn_high_cnt = csn ? csn_high_cnt + 1 : 0;
      check("core_dump_resetn", 64'(core_dump_resetn), 64'(!en));
      if (rst_cnt > 0 || en_low_cnt > 0) begin
         exp_addr = 0;
         check("idle_read_en", 64'(mem_read_en), 64'(0));
         check("idle_miso", 64'(miso), 64'(0));
         if (rst_cnt > 0 || en_low_cnt > 1)
            check("idle_addr", 64'(mem_read_addr), 64'(0));
      end else begin
         if (csn_high_cnt >= 2) check("csn_high_miso", 64'(miso), 64'(0));
         if (mem_read_en === 1'b1) begin
            check("strobe_addr", 64'(mem_read_addr), 64'(exp_addr));
            check("strobe_allowed", 64'(!LIMIT || exp_addr < MEM_BYTES), 64'(1));
            addr_log.push_back(mem_read_addr);
            exp_addr++;
            strobes++;
         end
      end
   end

   // ---------------- host tasks ----------------
   task automatic begin_frame();
      csn = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Clock n SCK pulses (clk/16), checking each MISO bit against the model.
   task automatic bits(input int n, output logic [63:0] rx);
      logic [7:0] b;
      rx = '0;
      for (int i = 0; i < n; i++) begin
         b = byte_at(ptr + i / 8);
         check("miso_bit", 64'(miso), 64'(b[7 - (i % 8)]));
         rx = {rx[62:0], miso};
         sck = 1'b1;
         repeat (8) @(negedge clk);
         sck = 1'b0;
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic frame(input int n, input int gap, output logic [63:0] rx);
      begin_frame();
      bits(n, rx);
      ptr += (n + 7) / 8;
      csn = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic restart();
      en = 1'b0;
      repeat (3) @(negedge clk);
      en  = 1'b1;
      ptr = 0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] rx;
      int idx0, s0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h01;
      mem[4] = 8'h5A; mem[5] = 8'hC3;

      repeat (5) @(negedge clk);
      check("rst_miso", 64'(miso), 64'(0));
      check("rst_read_en", 64'(mem_read_en), 64'(0));
      check("rst_addr", 64'(mem_read_addr), 64'(0));
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      // 1: 32 SCK in one frame
      idx0 = addr_log.size();
      restart();
      frame(32, 10, rx);
      check("t1_bytes", rx, 64'hA53CFF01);
      for (int k = 0; k < 4; k++)
         check("t1_strobe_order", 64'(addr_log[idx0 + k]), 64'(k));
      check("t1_strobe_count", 64'(addr_log.size() - idx0 >= (LIMIT ? 4 : 5)), 64'(1));

      // 2: two whole-byte frames
      restart();
      frame(8, 10, rx);
      check("t2_first", rx, 64'hA5);
      frame(8, 10, rx);
      check("t2_second", rx, 64'h3C);

      // 3: partial frame, remainder dropped
      restart();
      frame(4, 10, rx);
      check("t3_partial", rx, 64'hA);
      frame(8, 10, rx);
      check("t3_next", rx, 64'h3C);

      // 4: enable drop mid-frame, then re-enable from address 0
      restart();
      begin_frame();
      bits(12, rx);
      check("t4_partial", rx, 64'hA53);
      en = 1'b0;
      @(posedge clk); #1;
      check("t4_miso_off", 64'(miso), 64'(0));
      check("t4_read_en_off", 64'(mem_read_en), 64'(0));
      @(negedge clk);
      csn = 1'b1;
      repeat (10) @(negedge clk);
      idx0 = addr_log.size();
      en  = 1'b1;
      ptr = 0;
      repeat (12) @(negedge clk);
      frame(8, 10, rx);
      check("t4_after", rx, 64'hA5);
      check("t4_strobe_seen", 64'(addr_log.size() > idx0), 64'(1));
      check("t4_first_addr", 64'(addr_log[idx0]), 64'(0));

      // 5: reset pulse mid-byte
      restart();
      begin_frame();
      bits(12, rx);
      rstn = 1'b0;
      @(posedge clk); #1;
      check("t5_miso", 64'(miso), 64'(0));
      check("t5_read_en", 64'(mem_read_en), 64'(0));
      check("t5_addr", 64'(mem_read_addr), 64'(0));
      check("t5_core_rst", 64'(core_dump_resetn), 64'(0));
      @(negedge clk);
      csn = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      ptr  = 0;
      repeat (12) @(negedge clk);
      frame(8, 10, rx);
      check("t5_after", rx, 64'hA5);

      // 6: 48 SCK past the end of a 4-byte memory
      s0 = strobes;
      restart();
      frame(48, 10, rx);
      check("t6_bytes", rx, LIMIT ? 64'hA53CFF010000 : 64'hA53CFF015AC3);
      check("t6_strobes", 64'(LIMIT ? (strobes - s0 == 4) : (strobes - s0 >= 6)), 64'(1));

      // Random memory contents and frame lengths.
      for (int r = 0; r < 3; r++) begin
         en = 1'b0;
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         restart();
         for (int f = 0; f < 4; f++)
            frame($urandom_range(1, 24), $urandom_range(4, 12), rx);
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
